// File: rtl/alu_pkg.sv
// ALU operation codes and operand-forwarding selects shared by the execute stage.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_XOR = 4'b1001,
    ALU_NOR = 4'b1100,
    ALU_LUI = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, zero flag and signed overflow (ADD/SUB only).
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_control,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              ovf
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              add_ovf;
  logic              sub_ovf;
  logic              lt;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = $signed(a) < $signed(b);

  // Overflow when operand signs permit it and the result sign disagrees with a.
  assign add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1]  != a[DATA_W-1]);
  assign sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);

  always_comb begin
    result = sum;
    ovf    = 1'b0;
    case (alu_control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result = sum;
        ovf    = add_ovf;
      end
      ALU_SUB: begin
        result = diff;
        ovf    = sub_ovf;
      end
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, lt};
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_LUI: result = DATA_W'({b[15:0], 16'h0000});
      default: begin
        result = sum;
        ovf    = add_ovf;
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, operand-B select, ALU and the EX/MEM register.
module ex_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm_ext,
  input  logic              alu_src,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [DATA_W-1:0] exmem_fwd_data,
  input  logic [DATA_W-1:0] wb_fwd_data,
  input  logic [REG_W-1:0]  dest_reg_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_result_q,
  output logic [DATA_W-1:0] store_data_q,
  output logic [REG_W-1:0]  dest_reg_q,
  output logic              reg_write_q,
  output logic              mem_read_q,
  output logic              mem_write_q,
  output logic              valid_q,
  output logic              zero_q,
  output logic              ovf_q
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] rt_fwd;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              alu_ovf;

  logic              reg_write_d;
  logic              mem_read_d;
  logic              mem_write_d;
  logic              ovf_d;

  // Reserved select 2'b11 falls through to the register-file operand.
  always_comb begin
    op_a = rs_data;
    case (fwd_a)
      FWD_WB:  op_a = wb_fwd_data;
      FWD_MEM: op_a = exmem_fwd_data;
      default: op_a = rs_data;
    endcase
  end

  always_comb begin
    rt_fwd = rt_data;
    case (fwd_b)
      FWD_WB:  rt_fwd = wb_fwd_data;
      FWD_MEM: rt_fwd = exmem_fwd_data;
      default: rt_fwd = rt_data;
    endcase
  end

  assign op_b = alu_src ? imm_ext : rt_fwd;

  alu_core #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a          (op_a),
    .b          (op_b),
    .alu_control(alu_control),
    .result     (alu_res),
    .zero       (alu_zero),
    .ovf        (alu_ovf)
  );

  // Bubbles clear control; an overflowing instruction never writes back.
  always_comb begin
    ovf_d       = valid_in & alu_ovf;
    reg_write_d = valid_in & reg_write_in & ~alu_ovf;
    mem_read_d  = valid_in & mem_read_in;
    mem_write_d = valid_in & mem_write_in;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      alu_result_q <= '0;
      store_data_q <= '0;
      dest_reg_q   <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      valid_q      <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (!stall) begin
      alu_result_q <= alu_res;
      store_data_q <= rt_fwd;
      dest_reg_q   <= dest_reg_in;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      valid_q      <= valid_in;
      zero_q       <= alu_zero;
      ovf_q        <= ovf_d;
    end
  end

endmodule
